demux_1to2_buffered: RTL and testbench
======================================

// Module: demux_1to2_buffered
// PURPOSE
//  Registered 1-to-2 demultiplexer with valid/ready handshakes. It is the steering
//  counterpart of muxNby2to1: one WIDTH-bit input stream is routed to output 0 or 1 by a
//  per-beat select bit. Each output has a 2-entry FIFO, so both output sides are decoupled
//  from the input. Used in InstructionFetch to split fetched words between two consumers.
// PARAMETERS
//  WIDTH   16  data width in bits of the input and both outputs
//  CNT_W   8   width of the per-output accepted-beat counters (wrap at 2^CNT_W)
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        asynchronous, active-high; clears all state
//  in_data     in   WIDTH    input beat
//  in_sel      in   1        destination: 0 -> out0, 1 -> out1; qualified by in_valid
//  in_valid    in   1        input beat present
//  in_ready    out  1        block accepts the beat this cycle
//  out0_data   out  WIDTH    head of FIFO 0
//  out0_valid  out  1        FIFO 0 non-empty
//  out0_ready  in   1        consumer 0 takes the head
//  out1_data   out  WIDTH    head of FIFO 1
//  out1_valid  out  1        FIFO 1 non-empty
//  out1_ready  in   1        consumer 1 takes the head
//  cnt0        out  CNT_W    beats accepted into FIFO 0 since reset
//  cnt1        out  CNT_W    beats accepted into FIFO 1 since reset
// BEHAVIOUR
//  - Reset (async assert, sync release): both FIFOs empty, outN_valid=0, outN_data=0,
//    cnt0=cnt1=0, in_ready=1. Asserting reset mid-operation flushes buffered beats.
//  - Per FIFO: occupancy state EMPTY(0) / ONE(1) / FULL(2), two storage slots, a rd pointer.
//  - in_ready = (occupancy of FIFO[in_sel] != FULL). Depends on in_sel and registered
//    state only; never combinationally on out0_ready/out1_ready.
//  - Push: in_valid & in_ready at a clock edge writes in_data into FIFO[in_sel];
//    cntN (N=in_sel) increments by 1, wrapping from 2^CNT_W-1 to 0.
//  - Pop: outN_valid & outN_ready at a clock edge removes the head of FIFO N.
//  - Latency: beat accepted at edge k appears at outN_data/outN_valid after edge k
//    (1 cycle) if FIFO N was empty; otherwise behind earlier beats, order preserved.
//  - Transitions per FIFO: EMPTY+push->ONE; ONE+push->FULL; ONE+pop->EMPTY;
//    ONE+push+pop->ONE (new beat becomes head); FULL+pop->ONE; FULL+push is impossible
//    (in_ready=0). No bypass: an empty FIFO never shows the input on the same cycle.
//  - While outN_valid=1 and outN_ready=0, outN_data and outN_valid stay stable.
//  - outN_data is don't-care when outN_valid=0 (holds last value; 0 after reset).
//  - The two FIFOs are independent: a push to one and a pop from the other in the same
//    cycle both take effect; a full FIFO 0 does not stall beats with in_sel=1.
//  - in_sel and in_data are ignored when in_valid=0; in_ready is still driven.
// TESTING (WIDTH=16, CNT_W=8)
//  1 Reset then in_data=16'h0000,sel=0 and in_data=16'hFFFF,sel=1, both outN_ready=1 ->
//    out0_data=0 and out1_data=65535 each valid exactly 1 cycle after its accept; cnt0=cnt1=1.
//  2 out0_ready=0, push 16'h0001,0002,0003 with sel=0 -> first two accepted, in_ready=0 on
//    the third; raise out0_ready -> pops 1,2, then 3 is accepted and popped in order.
//  3 FIFO 0 full, push 16'hABCD with sel=1 -> accepted immediately, out1_data=ABCD next
//    cycle, FIFO 0 contents and out0_data unchanged.
//  4 FIFO 0 at ONE, same-cycle push 16'h0005 and pop -> occupancy stays ONE,
//    out0_data=0005 next cycle, out0_valid never drops.
//  5 256 beats with sel=1 -> cnt1 wraps to 0, cnt0 stays 0.
//  6 Assert reset asynchronously with both FIFOs FULL -> outN_valid=0, cnt0=cnt1=0,
//    in_ready=1 before the next clock edge.

Source files
------------

// File: rtl/demux_1to2_buffered.sv
// Registered 1-to-2 steering demux with valid/ready handshakes.
// Each output side has its own 2-entry FIFO and accepted-beat counter.

module demux_1to2_buffered_fifo #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]            occ;
  logic                  rd;
  logic [1:0][WIDTH-1:0] mem;
  logic                  do_push, do_pop;

  assign valid   = (occ != EMPTY);
  assign full    = (occ == FULL);
  assign head    = mem[rd];
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;

  // rd is left in place when draining to EMPTY so head keeps the last beat
  // and the next push lands in that same slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ <= EMPTY;
      rd  <= 1'b0;
      mem <= '0;
      cnt <= '0;
    end else begin
      if (do_push) cnt <= cnt + CNT_ONE;
      case (occ)
        EMPTY: begin
          if (do_push) begin
            mem[rd] <= push_data;
            occ     <= ONE;
          end
        end
        ONE: begin
          if (do_push && do_pop) begin
            mem[~rd] <= push_data;
            rd       <= ~rd;
          end else if (do_push) begin
            mem[~rd] <= push_data;
            occ      <= FULL;
          end else if (do_pop) begin
            occ <= EMPTY;
          end
        end
        FULL: begin
          if (do_pop) begin
            rd  <= ~rd;
            occ <= ONE;
          end
        end
        default: occ <= EMPTY;
      endcase
    end
  end
endmodule

module demux_1to2_buffered #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  logic [1:0][WIDTH-1:0] data;
  logic [1:0][CNT_W-1:0] cnt;
  logic [1:0]            valid, full, ready, push;

  // Backpressure looks only at the selected FIFO's registered state.
  assign in_ready = ~full[in_sel];
  assign ready    = {out1_ready, out0_ready};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    assign push[g] = in_valid & in_ready & (in_sel == 1'(g));
    demux_1to2_buffered_fifo #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[g]),
      .push_data (in_data),
      .pop       (ready[g]),
      .head      (data[g]),
      .valid     (valid[g]),
      .full      (full[g]),
      .cnt       (cnt[g])
    );
  end

  assign out0_data  = data[0];
  assign out1_data  = data[1];
  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];
endmodule

// File: tb/tb_demux_1to2_buffered.sv
// Directed bench for demux_1to2_buffered: handshakes, FIFO ordering,
// independence of the two sides, counter wrap and async reset flush.

module tb_demux_1to2_buffered;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_sel, in_valid, in_ready;
  logic [15:0] out0_data, out1_data;
  logic        out0_valid, out1_valid, out0_ready, out1_ready;
  logic [7:0]  cnt0, cnt1;

  int n_assert = 0;
  int n_fail   = 0;

  demux_1to2_buffered #(.WIDTH(16), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    #1;
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #12;
    chk("rst_v0", 32'(out0_valid), 0);
    chk("rst_v1", 32'(out1_valid), 0);
    chk("rst_d0", 32'(out0_data), 0);
    chk("rst_d1", 32'(out1_data), 0);
    chk("rst_cnt0", 32'(cnt0), 0);
    chk("rst_cnt1", 32'(cnt1), 0);
    chk("rst_rdy", 32'(in_ready), 1);
    reset = 1'b0;
    tick();

    // 1: extremes of data, one beat to each side, 1-cycle latency
    out0_ready = 1'b1; out1_ready = 1'b1;
    drive(1'b1, 1'b0, 16'h0000);
    chk("t1_rdy", 32'(in_ready), 1);
    chk("t1_nobypass", 32'(out0_valid), 0);
    tick();
    chk("t1_v0", 32'(out0_valid), 1);
    chk("t1_d0", 32'(out0_data), 32'h0000);
    drive(1'b1, 1'b1, 16'hFFFF);
    tick();
    chk("t1_v0_gone", 32'(out0_valid), 0);
    chk("t1_v1", 32'(out1_valid), 1);
    chk("t1_d1", 32'(out1_data), 32'hFFFF);
    drive(1'b0, 1'b0, 16'h0000);
    tick();
    chk("t1_v1_gone", 32'(out1_valid), 0);
    chk("t1_cnt0", 32'(cnt0), 1);
    chk("t1_cnt1", 32'(cnt1), 1);

    // 2: fill FIFO 0, backpressure, then drain in order
    out0_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0001);
    tick();
    drive(1'b1, 1'b0, 16'h0002);
    chk("t2_rdy2", 32'(in_ready), 1);
    tick();
    drive(1'b1, 1'b0, 16'h0003);
    chk("t2_rdy3", 32'(in_ready), 0);
    tick();
    chk("t2_hold_d", 32'(out0_data), 32'h0001);
    chk("t2_hold_v", 32'(out0_valid), 1);
    chk("t2_cnt0", 32'(cnt0), 3);
    out0_ready = 1'b1;
    #1;
    chk("t2_rdy_not_comb", 32'(in_ready), 0);
    tick();
    chk("t2_pop1", 32'(out0_data), 32'h0002);
    chk("t2_rdy_after", 32'(in_ready), 1);
    tick();
    chk("t2_pop2", 32'(out0_data), 32'h0003);
    chk("t2_v3", 32'(out0_valid), 1);
    chk("t2_cnt0b", 32'(cnt0), 4);
    drive(1'b0, 1'b0, 16'h0000);
    tick();
    chk("t2_empty", 32'(out0_valid), 0);
    chk("t2_holdlast", 32'(out0_data), 32'h0003);

    // 3: FIFO 0 full does not stall side 1
    out0_ready = 1'b0; out1_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0011);
    tick();
    drive(1'b1, 1'b0, 16'h0022);
    tick();
    drive(1'b1, 1'b1, 16'hABCD);
    chk("t3_rdy_sel1", 32'(in_ready), 1);
    tick();
    chk("t3_v1", 32'(out1_valid), 1);
    chk("t3_d1", 32'(out1_data), 32'hABCD);
    chk("t3_d0", 32'(out0_data), 32'h0011);
    chk("t3_cnt0", 32'(cnt0), 6);
    chk("t3_cnt1", 32'(cnt1), 2);
    drive(1'b0, 1'b0, 16'h0000);
    chk("t3_rdy_sel0", 32'(in_ready), 0);
    out1_ready = 1'b1; out0_ready = 1'b1;
    tick();
    chk("t3_v1_gone", 32'(out1_valid), 0);
    chk("t3_d0b", 32'(out0_data), 32'h0022);

    // 4: FIFO 0 at ONE, push and pop together
    drive(1'b1, 1'b0, 16'h0005);
    chk("t4_rdy", 32'(in_ready), 1);
    tick();
    chk("t4_v0", 32'(out0_valid), 1);
    chk("t4_d0", 32'(out0_data), 32'h0005);
    chk("t4_cnt0", 32'(cnt0), 7);
    drive(1'b0, 1'b0, 16'h0000);
    tick();
    chk("t4_empty", 32'(out0_valid), 0);

    // 5: 256 beats to side 1, counter wraps back to start
    for (int i = 0; i < 254; i++) begin
      drive(1'b1, 1'b1, 16'(i));
      tick();
    end
    chk("t5_wrap0", 32'(cnt1), 0);
    chk("t5_d1a", 32'(out1_data), 32'h00FD);
    for (int i = 254; i < 256; i++) begin
      drive(1'b1, 1'b1, 16'(i));
      tick();
    end
    chk("t5_cnt1", 32'(cnt1), 2);
    chk("t5_cnt0", 32'(cnt0), 7);
    chk("t5_d1b", 32'(out1_data), 32'h00FF);
    drive(1'b0, 1'b0, 16'h0000);
    tick();

    // 6: both FIFOs full, asynchronous reset mid-cycle
    out0_ready = 1'b0; out1_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0A01); tick();
    drive(1'b1, 1'b0, 16'h0A02); tick();
    drive(1'b1, 1'b1, 16'h0B01); tick();
    drive(1'b1, 1'b1, 16'h0B02); tick();
    chk("t6_full1", 32'(in_ready), 0);
    drive(1'b1, 1'b0, 16'h0A03);
    chk("t6_full0", 32'(in_ready), 0);
    drive(1'b0, 1'b0, 16'h0000);
    #1 reset = 1'b1;
    #1;
    chk("t6_v0", 32'(out0_valid), 0);
    chk("t6_v1", 32'(out1_valid), 0);
    chk("t6_cnt0", 32'(cnt0), 0);
    chk("t6_cnt1", 32'(cnt1), 0);
    chk("t6_rdy0", 32'(in_ready), 1);
    chk("t6_d0", 32'(out0_data), 0);
    drive(1'b0, 1'b1, 16'h0000);
    chk("t6_rdy1", 32'(in_ready), 1);
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 16'h0077);
    tick();
    chk("t6_post_d0", 32'(out0_data), 32'h0077);
    chk("t6_post_cnt0", 32'(cnt0), 1);
    drive(1'b0, 1'b0, 16'h0000);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
